// File: rtl/pci_pkg.sv
// Shared PCI definitions: bus widths, memory command codes, target FSM states
// and the address-phase payload view.
package pci_pkg;

  localparam int unsigned AD_W  = 32;
  localparam int unsigned CBE_W = 4;

  localparam logic [CBE_W-1:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [CBE_W-1:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_TURN,
    S_WDATA,
    S_RDATA,
    S_DISC
  } state_e;

  // What the bus carries during an address phase.
  typedef struct packed {
    logic [CBE_W-1:0] cmd;
    logic [AD_W-1:0]  addr;
  } addr_phase_t;

endpackage

// File: rtl/pci_target_param_if.sv
// Shared Frame/IRDY/CBE/AD bus. Each side owns one tri-state driver on AD;
// the drivers are resolved here so both agents see a single bus wire.
interface pci_target_param_if;
  import pci_pkg::*;

  logic              Frame;
  logic              IRDY;
  logic [CBE_W-1:0]  CBE;
  wire  [AD_W-1:0]   AddressDataLine;
  logic              DEVSEL;
  logic              TRDY;
  logic              STOP;

  logic              t_oe;
  logic [AD_W-1:0]   t_ad;
  logic              m_oe;
  logic [AD_W-1:0]   m_ad;

  assign AddressDataLine = t_oe ? t_ad : 'z;
  assign AddressDataLine = m_oe ? m_ad : 'z;

  modport slave (
    input  Frame, IRDY, CBE, AddressDataLine,
    output DEVSEL, TRDY, STOP, t_oe, t_ad
  );

  modport master (
    output Frame, IRDY, CBE, m_oe, m_ad,
    input  AddressDataLine, DEVSEL, TRDY, STOP, t_oe
  );

endinterface

// File: rtl/pci_target_mem.sv
// Target word buffer: byte-enabled synchronous write, asynchronous read.
// Contents are deliberately not reset.
module pci_target_mem
  import pci_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [CBE_W-1:0]         wbe,
  input  logic [AD_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AD_W-1:0]          rdata_c
);

  logic [AD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(CBE_W); b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/pci_target_param.sv
// PCI memory target: decodes a DEPTH-word window at BASE_ADDR, serves read and
// write bursts with initial wait states, and disconnects at the window end.
module pci_target_param
  import pci_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic               Clk,
  input logic               Rst,
  pci_target_param_if.slave bus
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;       // pointer can reach DEPTH after the final transfer
  localparam int unsigned OW  = AD_W + 1;
  localparam int unsigned WCW = 3;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic            is_rd_q, is_rd_d;
  logic            devsel_q, devsel_d;
  logic            trdy_q, trdy_d;
  logic            stop_q, stop_d;
  logic            oe_q, oe_d;
  logic [AD_W-1:0] ad_q, ad_d;

  addr_phase_t     ap_c;
  logic [OW-1:0]   off_c;
  logic            hit_c;
  logic            xfer_c;
  logic            last_c;
  logic            mem_we_c;
  logic [AW-1:0]   raddr_c;
  logic [AD_W-1:0] rdata_c;

  // Address decode; the extra top bit of the offset flags addresses below the base.
  assign ap_c   = '{cmd: bus.CBE, addr: bus.AddressDataLine};
  assign off_c  = {1'b0, ap_c.addr} - OW'(BASE_ADDR);
  assign hit_c  = !off_c[OW-1] && (off_c[AD_W-1:0] < AD_W'(DEPTH)) &&
                  ((ap_c.cmd == CMD_MEM_READ) || (ap_c.cmd == CMD_MEM_WRITE));
  assign xfer_c = !bus.IRDY && !trdy_q;
  assign last_c = (ptr_q == PW'(DEPTH - 1));

  // Reads prefetch the word the pointer moves to, so AD is valid right after a transfer.
  assign raddr_c = (state_q == S_RDATA) ? AW'(ptr_q + PW'(1)) : AW'(ptr_q);

  pci_target_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (Clk),
    .we      (mem_we_c),
    .waddr   (AW'(ptr_q)),
    .wbe     (~bus.CBE),
    .wdata   (bus.AddressDataLine),
    .raddr   (raddr_c),
    .rdata_c (rdata_c)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      wcnt_q   <= '0;
      is_rd_q  <= 1'b0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      oe_q     <= 1'b0;
      ad_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wcnt_q   <= wcnt_d;
      is_rd_q  <= is_rd_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      oe_q     <= oe_d;
      ad_q     <= ad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    is_rd_d  = is_rd_q;
    devsel_d = devsel_q;
    trdy_d   = trdy_q;
    stop_d   = stop_q;
    oe_d     = oe_q;
    ad_d     = ad_q;
    mem_we_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!bus.Frame && hit_c) begin
          devsel_d = 1'b0;
          ptr_d    = PW'(off_c);
          is_rd_d  = (ap_c.cmd == CMD_MEM_READ);
          if (ap_c.cmd == CMD_MEM_READ) begin
            state_d = S_TURN;
          end else if (WAIT_STATES == 0) begin
            state_d = S_WDATA;
            trdy_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WCW'(WAIT_STATES);
          end
        end
      end

      // Bus turnaround: the master has released AD, we have not yet driven it.
      S_TURN: begin
        if (WAIT_STATES == 0) begin
          state_d = S_RDATA;
          trdy_d  = 1'b0;
          oe_d    = 1'b1;
          ad_d    = rdata_c;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = WCW'(WAIT_STATES);
        end
      end

      S_WAIT: begin
        if (wcnt_q <= WCW'(1)) begin
          wcnt_d = '0;
          trdy_d = 1'b0;
          if (is_rd_q) begin
            state_d = S_RDATA;
            oe_d    = 1'b1;
            ad_d    = rdata_c;
          end else begin
            state_d = S_WDATA;
          end
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end

      S_WDATA: begin
        if (xfer_c) begin
          mem_we_c = 1'b1;
          ptr_d    = ptr_q + PW'(1);
          if (bus.Frame) begin
            state_d  = S_IDLE;
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
          end else if (last_c) begin
            state_d = S_DISC;
            trdy_d  = 1'b1;
            stop_d  = 1'b0;
          end
        end
      end

      S_RDATA: begin
        if (xfer_c) begin
          ptr_d = ptr_q + PW'(1);
          if (bus.Frame) begin
            state_d  = S_IDLE;
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
            oe_d     = 1'b0;
          end else if (last_c) begin
            state_d = S_DISC;
            trdy_d  = 1'b1;
            stop_d  = 1'b0;
          end else begin
            ad_d = rdata_c;
          end
        end
      end

      S_DISC: begin
        if (bus.Frame) begin
          state_d  = S_IDLE;
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
          stop_d   = 1'b1;
          oe_d     = 1'b0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        devsel_d = 1'b1;
        trdy_d   = 1'b1;
        stop_d   = 1'b1;
        oe_d     = 1'b0;
      end
    endcase
  end

  assign bus.DEVSEL = devsel_q;
  assign bus.TRDY   = trdy_q;
  assign bus.STOP   = stop_q;
  assign bus.t_oe   = oe_q;
  assign bus.t_ad   = ad_q;

endmodule

// File: tb/tb_pci_target_param.sv
// Directed bench: two targets share one master; A has window 0..7 with two wait
// states, B has window 16..23 with no wait states.
module tb_pci_target_param;
  import pci_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame, irdy, m_oe;
  logic [3:0]  cbe;
  logic [31:0] m_ad;
  int          total = 0;
  int          bad   = 0;

  // Status nibble {DEVSEL, TRDY, STOP, target AD enable}
  localparam logic [3:0] IDL = 4'b1110;  // idle, AD released
  localparam logic [3:0] TW  = 4'b0110;  // claimed, turnaround or wait state
  localparam logic [3:0] WD  = 4'b0010;  // write data phase
  localparam logic [3:0] RD  = 4'b0011;  // read data phase, AD driven
  localparam logic [3:0] DW  = 4'b0100;  // disconnect after write
  localparam logic [3:0] DR  = 4'b0101;  // disconnect after read
  localparam logic [3:0] C_RD = 4'b0110;
  localparam logic [3:0] C_WR = 4'b0111;

  always #5 clk = ~clk;

  pci_target_param_if ifa ();
  pci_target_param_if ifb ();

  assign ifa.Frame = frame;
  assign ifa.IRDY  = irdy;
  assign ifa.CBE   = cbe;
  assign ifa.m_oe  = m_oe;
  assign ifa.m_ad  = m_ad;
  assign ifb.Frame = frame;
  assign ifb.IRDY  = irdy;
  assign ifb.CBE   = cbe;
  assign ifb.m_oe  = m_oe;
  assign ifb.m_ad  = m_ad;

  pci_target_param #(.DEPTH(8), .BASE_ADDR(0),  .WAIT_STATES(2)) dut_a (
    .Clk(clk), .Rst(rst_n), .bus(ifa.slave));
  pci_target_param #(.DEPTH(8), .BASE_ADDR(16), .WAIT_STATES(0)) dut_b (
    .Clk(clk), .Rst(rst_n), .bus(ifb.slave));

  wire [3:0]  sa  = {ifa.DEVSEL, ifa.TRDY, ifa.STOP, ifa.t_oe};
  wire [3:0]  sb  = {ifb.DEVSEL, ifb.TRDY, ifb.STOP, ifb.t_oe};
  wire [31:0] ada = ifa.AddressDataLine;
  wire [31:0] adb = ifb.AddressDataLine;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one bus cycle, then look just after the edge that samples it.
  task automatic cyc(input logic f, input logic i, input logic [3:0] c,
                     input logic oe, input logic [31:0] d);
    frame = f; irdy = i; cbe = c; m_oe = oe; m_ad = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame = 1'b1; irdy = 1'b1; cbe = 4'h0; m_oe = 1'b0; m_ad = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", 32'(sa), 32'(IDL));
    chk("reset_b", 32'(sb), 32'(IDL));
    rst_n = 1'b1;
    idle();

    // B: three-word write burst from word 16, no wait states
    cyc(1'b0, 1'b1, C_WR, 1'b1, 32'd16);        chk("bw_addr", 32'(sb), 32'(WD));
    chk("bw_a_miss", 32'(sa), 32'(IDL));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'h12345678);  chk("bw_d0", 32'(sb), 32'(WD));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'h33345633);  chk("bw_d1", 32'(sb), 32'(WD));
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 32'h44442222);  chk("bw_end", 32'(sb), 32'(IDL));
    idle();

    // B: read the burst back
    cyc(1'b0, 1'b1, C_RD, 1'b1, 32'd16);        chk("br_turn", 32'(sb), 32'(TW));
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("br_s0", 32'(sb), 32'(RD));
    chk("br_w0", adb, 32'h12345678);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("br_w1", adb, 32'h33345633);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("br_w2", adb, 32'h44442222);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("br_end", 32'(sb), 32'(IDL));
    idle();

    // B: byte enables on word 17
    cyc(1'b0, 1'b1, C_WR, 1'b1, 32'd17);
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 32'h11111111);  chk("be_w1", 32'(sb), 32'(IDL));
    idle();
    cyc(1'b0, 1'b1, C_WR, 1'b1, 32'd17);
    cyc(1'b1, 1'b0, 4'b1010, 1'b1, 32'hFFFFFFFF);
    idle();
    cyc(1'b0, 1'b1, C_RD, 1'b1, 32'd17);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("be_rd", adb, 32'h11FF11FF);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("be_end", 32'(sb), 32'(IDL));
    idle();

    // A: write words 0,1 through two wait states
    cyc(1'b0, 1'b1, C_WR, 1'b1, 32'd0);         chk("aw_wait1", 32'(sa), 32'(TW));
    chk("aw_b_miss", 32'(sb), 32'(IDL));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'h12345678);  chk("aw_wait2", 32'(sa), 32'(TW));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'h12345678);  chk("aw_data", 32'(sa), 32'(WD));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'h12345678);  chk("aw_d0", 32'(sa), 32'(WD));
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 32'h33345633);  chk("aw_end", 32'(sa), 32'(IDL));
    idle();

    // A: read with turnaround, wait states and a two-cycle master stall
    cyc(1'b0, 1'b1, C_RD, 1'b1, 32'd0);         chk("ar_turn", 32'(sa), 32'(TW));
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("ar_wait1", 32'(sa), 32'(TW));
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("ar_wait2", 32'(sa), 32'(TW));
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("ar_s0", 32'(sa), 32'(RD));
    chk("ar_w0", ada, 32'h12345678);
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 32'h0);         chk("ar_stall1", ada, 32'h12345678);
    cyc(1'b0, 1'b1, 4'h0, 1'b0, 32'h0);         chk("ar_stall2", ada, 32'h12345678);
    chk("ar_stall_s", 32'(sa), 32'(RD));
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("ar_w1", ada, 32'h33345633);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("ar_end", 32'(sa), 32'(IDL));
    idle();

    // A: write burst from word 6 runs off the window end
    cyc(1'b0, 1'b1, C_WR, 1'b1, 32'd6);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'hAAAA0006);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'hAAAA0006);  chk("dw_data", 32'(sa), 32'(WD));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'hAAAA0006);  chk("dw_x6", 32'(sa), 32'(WD));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'hAAAA0007);  chk("dw_stop", 32'(sa), 32'(DW));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'hAAAA0008);  chk("dw_hold", 32'(sa), 32'(DW));
    cyc(1'b1, 1'b0, 4'h0, 1'b1, 32'hAAAA0009);  chk("dw_rel", 32'(sa), 32'(IDL));
    idle();

    // A: read words 6,7 back, disconnect with AD still driven
    cyc(1'b0, 1'b1, C_RD, 1'b1, 32'd6);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("dr_w6", ada, 32'hAAAA0006);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("dr_w7", ada, 32'hAAAA0007);
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 32'h0);         chk("dr_stop", 32'(sa), 32'(DR));
    cyc(1'b1, 1'b1, 4'h0, 1'b0, 32'h0);         chk("dr_rel", 32'(sa), 32'(IDL));
    idle();

    // A: word 0 must be untouched by the disconnected burst
    cyc(1'b0, 1'b1, C_RD, 1'b1, 32'd0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("w0_keep", ada, 32'h12345678);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("w0_end", 32'(sa), 32'(IDL));
    idle();

    // Misses: bad command, one past A's window, one past B's window
    cyc(1'b0, 1'b1, 4'b0010, 1'b1, 32'd0);      chk("miss_cmd_a", 32'(sa), 32'(IDL));
    chk("miss_cmd_b", 32'(sb), 32'(IDL));
    idle();                                     chk("miss_cmd_a2", 32'(sa), 32'(IDL));
    cyc(1'b0, 1'b1, C_RD, 1'b1, 32'd8);         chk("miss_a_end", 32'(sa), 32'(IDL));
    chk("miss_8_b", 32'(sb), 32'(IDL));
    idle();
    cyc(1'b0, 1'b1, C_WR, 1'b1, 32'd24);        chk("miss_b_end", 32'(sb), 32'(IDL));
    idle();                                     chk("miss_b_end2", 32'(sb), 32'(IDL));

    // Reset asserted mid-burst on B, just before a transfer edge
    cyc(1'b0, 1'b1, C_WR, 1'b1, 32'd18);        chk("rst_pre", 32'(sb), 32'(WD));
    frame = 1'b0; irdy = 1'b0; cbe = 4'h0; m_oe = 1'b1; m_ad = 32'hBADBAD00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_now_b", 32'(sb), 32'(IDL));
    chk("rst_now_a", 32'(sa), 32'(IDL));
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'hBADBAD00);
    cyc(1'b0, 1'b0, 4'h0, 1'b1, 32'hBADBAD00);  chk("rst_held", 32'(sb), 32'(IDL));
    frame = 1'b1; irdy = 1'b1; m_oe = 1'b0;
    rst_n = 1'b1;
    idle();
    cyc(1'b0, 1'b1, C_RD, 1'b1, 32'd18);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("rst_nowrite", adb, 32'h44442222);
    cyc(1'b1, 1'b0, 4'h0, 1'b0, 32'h0);         chk("rst_end", 32'(sb), 32'(IDL));
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
